// File: rtl/crc5_checker_pkg.sv
// -----------------------------------------------------------------------------
// crc_pkg
// Shared CRC-5 definitions for the link generator and checker.
//   CRC5_W      : CRC width (5)
//   CRC5_POLY   : generator x^5+x^2+1 with the x^5 term implicit
//   CRC_DATA_W  : default message width (16)
//   crc5_advance: one serial step of the CRC (MSB-first, no reflection)
// -----------------------------------------------------------------------------
package crc_pkg;

  localparam int              CRC5_W     = 5;
  localparam logic [CRC5_W-1:0] CRC5_POLY = 5'h05;
  localparam int              CRC_DATA_W = 16;

  // Serial reference step: feed one message bit b into the CRC register.
  function automatic logic [CRC5_W-1:0] crc5_advance(input logic [CRC5_W-1:0] crc,
                                                     input logic              b);
    logic fb;
    fb = crc[CRC5_W-1] ^ b;
    return {crc[CRC5_W-2:0], 1'b0} ^ (fb ? CRC5_POLY : '0);
  endfunction

endpackage

// File: rtl/crc5_checker_if.sv
// -----------------------------------------------------------------------------
// crc5_checker_if
// Codeword-in / result-out handshake bundle of the CRC-5 checker.
//   in_valid/in_ready        : codeword handshake
//   in_data/in_crc           : received message and CRC
//   out_valid/out_ready      : result handshake
//   out_data/out_ok/out_syndrome : message, pass flag, recomputed CRC ^ in_crc
// master = producer/consumer side (drives codewords, accepts results),
// slave  = the checker.
// -----------------------------------------------------------------------------
interface crc5_checker_if #(
  parameter int DATA_W = 16,
  parameter int CRC_W  = 5
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CRC_W-1:0]  in_crc;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_ok;
  logic [CRC_W-1:0]  out_syndrome;

  modport master (
    output in_valid, in_data, in_crc, out_ready,
    input  in_ready, out_valid, out_data, out_ok, out_syndrome
  );

  modport slave (
    input  in_valid, in_data, in_crc, out_ready,
    output in_ready, out_valid, out_data, out_ok, out_syndrome
  );

endinterface

// File: rtl/crc5_checker_slice.sv
// -----------------------------------------------------------------------------
// crc_slice
// Combinational CRC update over a SLICE_W-bit data slice, MSB first. This is
// the serial reference step unrolled SLICE_W times; shared with the generator.
//   i_crc  : CRC state before the slice
//   i_data : message bits, bit SLICE_W-1 enters first
//   o_crc  : CRC state after the slice
// -----------------------------------------------------------------------------
module crc_slice #(
  parameter int               SLICE_W = 8,
  parameter int               CRC_W   = 5,
  parameter logic [CRC_W-1:0] POLY    = 5'h05
) (
  input  logic [CRC_W-1:0]   i_crc,
  input  logic [SLICE_W-1:0] i_data,
  output logic [CRC_W-1:0]   o_crc
);

  logic [CRC_W-1:0] w_crc;
  logic             w_fb;

  always_comb begin
    // NOTE: combinational logic uses blocking assignments, and every variable
    // gets a value before any branch or loop so no latch can be inferred.
    w_crc = i_crc;
    w_fb  = 1'b0;
    for (int i = SLICE_W - 1; i >= 0; i--) begin
      w_fb  = w_crc[CRC_W-1] ^ i_data[i];
      w_crc = {w_crc[CRC_W-2:0], 1'b0} ^ (w_fb ? POLY : '0);
    end
    o_crc = w_crc;
  end

endmodule

// File: rtl/crc5_checker.sv
// -----------------------------------------------------------------------------
// crc5_checker
// Receive-side CRC-5 checker. Recomputes the CRC of each 16-bit message in a
// two-stage pipeline (high half, then low half), compares it with the received
// CRC and hands off message + pass flag + syndrome. Keeps saturating counts of
// handed-off results and of failing results.
//   clk, rst  : rising-edge clock, synchronous active-high reset
//   bus       : crc5_checker_if.slave (codeword in, result out)
//   pkt_count : results handed off since reset (saturating)
//   err_count : handed-off results with out_ok=0 (saturating)
// DATA_W must be even: each stage covers one half of the message.
// -----------------------------------------------------------------------------
module crc5_checker
  import crc_pkg::*;
#(
  parameter int               DATA_W = CRC_DATA_W,
  parameter int               CRC_W  = CRC5_W,
  parameter logic [CRC_W-1:0] POLY   = CRC5_POLY,
  parameter int               CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  crc5_checker_if.slave        bus,
  output logic [CNT_W-1:0]     pkt_count,
  output logic [CNT_W-1:0]     err_count
);

  localparam int               HALF_W  = DATA_W / 2;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  // Stage 1 registers
  logic              r_s1_valid;
  logic [CRC_W-1:0]  r_s1_crc;     // partial CRC over the high half
  logic [DATA_W-1:0] r_s1_data;
  logic [CRC_W-1:0]  r_s1_rx_crc;  // received CRC carried alongside

  // Stage 2 / output registers
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_ok;
  logic [CRC_W-1:0]  r_out_syndrome;

  logic [CNT_W-1:0]  r_pkt_count;
  logic [CNT_W-1:0]  r_err_count;

  logic              w_en;
  logic              w_handoff;
  logic [CRC_W-1:0]  w_s1_crc;
  logic [CRC_W-1:0]  w_s2_crc;
  logic [CRC_W-1:0]  w_s2_syndrome;

  // The whole pipeline moves in lock-step: it advances whenever the output
  // register is empty or being drained this cycle. Bubbles are not squeezed.
  assign w_en      = !r_out_valid || bus.out_ready;
  assign w_handoff = r_out_valid && bus.out_ready;

  crc_slice #(
    .SLICE_W (HALF_W),
    .CRC_W   (CRC_W),
    .POLY    (POLY)
  ) u_slice_hi (
    .i_crc  ('0),
    .i_data (bus.in_data[DATA_W-1:HALF_W]),
    .o_crc  (w_s1_crc)
  );

  crc_slice #(
    .SLICE_W (HALF_W),
    .CRC_W   (CRC_W),
    .POLY    (POLY)
  ) u_slice_lo (
    .i_crc  (r_s1_crc),
    .i_data (r_s1_data[HALF_W-1:0]),
    .o_crc  (w_s2_crc)
  );

  assign w_s2_syndrome = w_s2_crc ^ r_s1_rx_crc;

  // Pipeline control and output fields.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    if (rst) begin
      r_s1_valid     <= 1'b0;
      r_out_valid    <= 1'b0;
      r_out_data     <= '0;
      r_out_ok       <= 1'b1;
      r_out_syndrome <= '0;
    end else if (w_en) begin
      r_s1_valid     <= bus.in_valid;
      r_out_valid    <= r_s1_valid;
      r_out_data     <= r_s1_data;
      r_out_ok       <= (w_s2_syndrome == '0);
      r_out_syndrome <= w_s2_syndrome;
    end
  end

  // NOTE: stage-1 payload is qualified by r_s1_valid, so it is left out of
  // reset; only state that is visible or controls flow is reset.
  always_ff @(posedge clk) begin
    if (w_en) begin
      r_s1_crc    <= w_s1_crc;
      r_s1_data   <= bus.in_data;
      r_s1_rx_crc <= bus.in_crc;
    end
  end

  // Statistics: count hand-offs only, pinned at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pkt_count <= '0;
      r_err_count <= '0;
    end else if (w_handoff) begin
      if (r_pkt_count != '1) r_pkt_count <= r_pkt_count + CNT_ONE;
      if (!r_out_ok && (r_err_count != '1)) r_err_count <= r_err_count + CNT_ONE;
    end
  end

  assign bus.in_ready     = w_en;
  assign bus.out_valid    = r_out_valid;
  assign bus.out_data     = r_out_data;
  assign bus.out_ok       = r_out_ok;
  assign bus.out_syndrome = r_out_syndrome;
  assign pkt_count        = r_pkt_count;
  assign err_count        = r_err_count;

endmodule

// File: tb/tb_crc5_checker.sv
// -----------------------------------------------------------------------------
// tb_crc5_checker
// Directed test of crc5_checker. Expected CRCs were worked out by hand as
// M(x)*x^5 mod (x^5+x^2+1):
//   0x0001 -> 05, 0x911C -> 00, 0x0000 -> 00, 0x8000 -> 0C,
//   0xFFFF -> 0B, 0x0100 -> 1C.
// A second instance with CNT_W=4 covers counter saturation.
// -----------------------------------------------------------------------------
module tb_crc5_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  crc5_checker_if #(.DATA_W(16), .CRC_W(5)) bus  ();
  crc5_checker_if #(.DATA_W(16), .CRC_W(5)) bus2 ();

  logic [15:0] pkt_count, err_count;
  logic [3:0]  pkt_count2, err_count2;

  crc5_checker #(.CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .pkt_count (pkt_count),
    .err_count (err_count)
  );

  crc5_checker #(.CNT_W(4)) dut_sat (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus2),
    .pkt_count (pkt_count2),
    .err_count (err_count2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] b2b_data [4] = '{16'h911C, 16'h0000, 16'h0001, 16'h0001};
  logic [4:0]  b2b_crc  [4] = '{5'h00,    5'h00,    5'h05,    5'h04};
  logic        b2b_ok   [4] = '{1'b1,     1'b1,     1'b1,     1'b0};
  logic [4:0]  b2b_syn  [4] = '{5'h00,    5'h00,    5'h00,    5'h01};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] d, input logic [4:0] c);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_crc   = c;
  endtask

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.in_crc     = '0;
    bus.out_ready  = 1'b1;
    bus2.in_valid  = 1'b0;
    bus2.in_data   = '0;
    bus2.in_crc    = '0;
    bus2.out_ready = 1'b1;

    // ---- Reset state
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_in_ready",  32'(bus.in_ready), 32'h1);
    check("rst_out_ok",    32'(bus.out_ok), 32'h1);
    check("rst_syndrome",  32'(bus.out_syndrome), 32'h0);
    check("rst_out_data",  32'(bus.out_data), 32'h0);
    check("rst_pkt",       32'(pkt_count), 32'h0);
    check("rst_err",       32'(err_count), 32'h0);

    // ---- Good codeword, latency
    drive(16'h0001, 5'h05);
    tick();                        // accepted into stage 1
    bus.in_valid = 1'b0;
    check("lat_s1_only", 32'(bus.out_valid), 32'h0);
    tick();
    check("good_valid", 32'(bus.out_valid), 32'h1);
    check("good_ok",    32'(bus.out_ok), 32'h1);
    check("good_syn",   32'(bus.out_syndrome), 32'h0);
    check("good_data",  32'(bus.out_data), 32'h0001);
    tick();                        // hand-off
    check("good_pkt",   32'(pkt_count), 32'd1);
    check("good_err",   32'(err_count), 32'd0);
    check("good_drain", 32'(bus.out_valid), 32'h0);

    // ---- Bad codeword
    drive(16'h0001, 5'h00);
    tick();
    bus.in_valid = 1'b0;
    tick();
    check("bad_ok",  32'(bus.out_ok), 32'h0);
    check("bad_syn", 32'(bus.out_syndrome), 32'h05);
    tick();
    check("bad_pkt", 32'(pkt_count), 32'd2);
    check("bad_err", 32'(err_count), 32'd1);

    // ---- Back-to-back stream: results on consecutive cycles
    for (int i = 0; i < 6; i++) begin
      if (i < 4) drive(b2b_data[i], b2b_crc[i]);
      else       bus.in_valid = 1'b0;
      tick();
      if (i >= 1 && i <= 4) begin
        check($sformatf("b2b%0d_valid", i - 1), 32'(bus.out_valid), 32'h1);
        check($sformatf("b2b%0d_data", i - 1),  32'(bus.out_data), 32'(b2b_data[i-1]));
        check($sformatf("b2b%0d_ok", i - 1),    32'(bus.out_ok), 32'(b2b_ok[i-1]));
        check($sformatf("b2b%0d_syn", i - 1),   32'(bus.out_syndrome), 32'(b2b_syn[i-1]));
      end
    end
    check("b2b_pkt", 32'(pkt_count), 32'd6);
    check("b2b_err", 32'(err_count), 32'd2);

    // ---- Backpressure: A in output, B in stage 1, C offered while stalled
    drive(16'h8000, 5'h0C);
    tick();
    drive(16'hFFFF, 5'h0B);
    tick();
    bus.out_ready = 1'b0;
    drive(16'h0100, 5'h1C);
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("bp%0d_in_ready", k), 32'(bus.in_ready), 32'h0);
      check($sformatf("bp%0d_valid", k),    32'(bus.out_valid), 32'h1);
      check($sformatf("bp%0d_data", k),     32'(bus.out_data), 32'h8000);
      check($sformatf("bp%0d_syn", k),      32'(bus.out_syndrome), 32'h0);
      check($sformatf("bp%0d_pkt", k),      32'(pkt_count), 32'd6);
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(bus.in_ready), 32'h1);
    tick();                        // A handed off, C accepted
    bus.in_valid = 1'b0;
    check("bp_b_data", 32'(bus.out_data), 32'hFFFF);
    check("bp_b_ok",   32'(bus.out_ok), 32'h1);
    check("bp_pkt_a",  32'(pkt_count), 32'd7);
    tick();
    check("bp_c_valid", 32'(bus.out_valid), 32'h1);
    check("bp_c_data",  32'(bus.out_data), 32'h0100);
    check("bp_c_ok",    32'(bus.out_ok), 32'h1);
    check("bp_pkt_b",   32'(pkt_count), 32'd8);
    tick();
    check("bp_empty", 32'(bus.out_valid), 32'h0);
    check("bp_pkt_c", 32'(pkt_count), 32'd9);
    check("bp_err",   32'(err_count), 32'd2);

    // ---- Reset with both stages full (output pending and being accepted)
    drive(16'h0001, 5'h00);
    tick();
    drive(16'h0001, 5'h05);
    tick();
    bus.in_valid = 1'b0;
    check("mid_full", 32'(bus.out_valid), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_out_valid", 32'(bus.out_valid), 32'h0);
    check("mid_pkt",       32'(pkt_count), 32'd0);
    check("mid_err",       32'(err_count), 32'd0);
    check("mid_in_ready",  32'(bus.in_ready), 32'h1);
    tick();
    check("mid_s1_dropped", 32'(bus.out_valid), 32'h0);
    check("mid_pkt_after",  32'(pkt_count), 32'd0);

    // ---- Saturation on the 4-bit counter instance: 20 failing codewords
    bus2.in_data = 16'h0001;
    bus2.in_crc  = 5'h00;
    for (int i = 0; i < 20; i++) begin
      bus2.in_valid = 1'b1;
      tick();
      if (i == 2) check("sat_ok", 32'(bus2.out_ok), 32'h0);
    end
    bus2.in_valid = 1'b0;
    tick();
    tick();
    tick();
    check("sat_pkt", 32'(pkt_count2), 32'hF);
    check("sat_err", 32'(err_count2), 32'hF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
